// File: rtl/aes_inv_sbox.sv
// AES inverse S-box: combinational 256-entry byte substitution.
// Used by the InvSubBytes stage of the iterative decryptor.
module aes_inv_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    localparam logic [2047:0] ISBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    logic [10:0] idx;

    assign idx = {~a_i, 3'b000};
    assign y_o = ISBOX[idx +: 8];

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box: combinational 256-entry byte substitution.
// Used by the key schedule (SubWord) of the iterative decryptor.
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry a sits at bit offset 8*(255-a), i.e. {~a, 3'b000}.
    logic [10:0] idx;

    assign idx = {~a_i, 3'b000};
    assign y_o = SBOX[idx +: 8];

endmodule

// File: rtl/aes_decry_iter.sv
// Iterative AES-128 decryptor: forward key expansion to K10, then ten
// inverse rounds at one per clock with round keys unwound on the fly.
module aes_decry_iter #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] i_block,
    input  logic [127:0] key,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [127:0] o_block
);

    localparam int unsigned BW = 128;
    localparam int unsigned WW = 32;
    localparam int unsigned RW = 4;

    typedef enum logic [1:0] {IDLE, KEXP, DEC} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   ct_q, ct_d;
    logic [BW-1:0]   st_q, st_d;
    logic [BW-1:0]   rk_q, rk_d;
    logic [BW-1:0]   o_block_q, o_block_d;
    logic [RW-1:0]   rnd_q, rnd_d;
    logic            done_q, done_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column of InvMixColumns; 0E/0B/0D/09 built from x2/x4/x8 chains.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        end
        return r;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Data path: InvShiftRows folded into the inverse S-box input wiring.
    logic [BW-1:0] isb;

    for (genvar gi = 0; gi < 16; gi++) begin : g_inv_sub
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
        aes_inv_sbox u_isbox (
            .a_i (st_q[127-8*SRC -: 8]),
            .y_o (isb[127-8*gi -: 8])
        );
    end

    // Key path: the four S-boxes serve both the forward and the reverse step.
    logic [WW-1:0] w0, w1, w2, w3;
    logic [WW-1:0] ks_word, ks_rot, ks_sub, ks_g;
    logic [RW-1:0] rcon_idx;
    logic [BW-1:0] rk_fwd, rk_bwd, t_round;

    assign w0 = rk_q[127:96];
    assign w1 = rk_q[95:64];
    assign w2 = rk_q[63:32];
    assign w3 = rk_q[31:0];

    assign ks_word  = (state_q == KEXP) ? w3 : (w3 ^ w2);
    assign ks_rot   = {ks_word[23:0], ks_word[31:24]};
    assign rcon_idx = (state_q == KEXP) ? RW'(rnd_q + RW'(1)) : rnd_q;

    for (genvar gk = 0; gk < 4; gk++) begin : g_key_sub
        aes_sbox u_sbox (
            .a_i (ks_rot[31-8*gk -: 8]),
            .y_o (ks_sub[31-8*gk -: 8])
        );
    end

    assign ks_g = ks_sub ^ {rcon(rcon_idx), 24'h000000};

    always_comb begin
        logic [WW-1:0] e0, e1, e2, e3;
        e0     = w0 ^ ks_g;
        e1     = w1 ^ e0;
        e2     = w2 ^ e1;
        e3     = w3 ^ e2;
        rk_fwd = {e0, e1, e2, e3};
    end

    assign rk_bwd  = {w0 ^ ks_g, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    assign t_round = isb ^ rk_bwd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ct_q      <= '0;
            st_q      <= '0;
            rk_q      <= '0;
            o_block_q <= '0;
            rnd_q     <= '0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ct_q      <= ct_d;
            st_q      <= st_d;
            rk_q      <= rk_d;
            o_block_q <= o_block_d;
            rnd_q     <= rnd_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ct_d      = ct_q;
        st_d      = st_q;
        rk_d      = rk_q;
        o_block_d = o_block_q;
        rnd_d     = rnd_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ct_d    = i_block;
                    rk_d    = key;
                    rnd_d   = '0;
                    state_d = KEXP;
                end
            end
            KEXP: begin
                rk_d  = rk_fwd;
                rnd_d = RW'(rnd_q + RW'(1));
                if (rnd_q == RW'(NR - 1)) begin
                    st_d    = ct_q ^ rk_fwd;
                    rnd_d   = RW'(NR);
                    state_d = DEC;
                end
            end
            DEC: begin
                // Final step also unwinds rk to K0, leaving the cipher key behind.
                rk_d = rk_bwd;
                if (rnd_q > RW'(1)) begin
                    st_d  = inv_mix(t_round);
                    rnd_d = RW'(rnd_q - RW'(1));
                end else begin
                    o_block_d = t_round;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    assign ready   = ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign o_block = o_block_q;

endmodule

// File: tb/tb_aes_decry_iter.sv
// Scoreboard bench for aes_decry_iter using FIPS-197 known-answer vectors.
module tb_aes_decry_iter;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [127:0] i_block = '0;
    logic [127:0] key = '0;
    logic         ready, busy, done;
    logic [127:0] o_block;

    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    int           acc_cnt = 0;
    int           done_cnt = 0;
    int           last_done_cyc = 0;
    int           prev_done_cyc = 0;
    logic [127:0] cur_exp = '0;
    logic [127:0] last_o = '0;
    logic [127:0] exp_q[$];
    int           acc_q[$];
    logic [127:0] mon_exp;
    int           mon_acc;

    aes_decry_iter #(.NR(10)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .i_block (i_block),
        .key     (key),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .o_block (o_block)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Accept detector: values seen here are the pre-edge ones the DUT samples.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst && start && ready) begin
            acc_q.push_back(cyc);
            exp_q.push_back(cur_exp);
            acc_cnt++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_cnt++;
                prev_done_cyc = last_done_cyc;
                last_done_cyc = cyc;
                chk("done_expected", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    mon_acc = acc_q.pop_front();
                    chk("plaintext", o_block, mon_exp);
                    chk("latency", 128'(cyc - mon_acc), 128'(20));
                end
                chk("ready_at_done", 128'(ready), 128'(1));
                chk("busy_at_done", 128'(busy), 128'(0));
                last_o = o_block;
            end else begin
                chk("o_block_hold", o_block, last_o);
            end
        end
    end

    task automatic issue(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] e);
        @(negedge clk);
        i_block = ct;
        key     = k;
        cur_exp = e;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k;
        k = 0;
        while (done_cnt < target && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("done_timeout", 128'(done_cnt >= target), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 128'(ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_o_block", o_block, 128'(0));
        rst = 1'b0;

        // FIPS-197 App. B with key-schedule probes
        issue(CT_B, KEY_B, PT_B);
        chk("busy_after_accept", 128'(busy), 128'(1));
        chk("ready_after_accept", 128'(ready), 128'(0));
        repeat (10) @(negedge clk);
        chk("rk_at_dec_entry", dut.rk_q, K10_B);
        wait_done(1);
        chk("rk_after_final", dut.rk_q, KEY_B);

        // FIPS-197 C.1
        issue(CT_C, KEY_C, PT_C);
        wait_done(2);

        // Back-to-back with start held high
        @(negedge clk);
        i_block = CT_B;
        key     = KEY_B;
        cur_exp = PT_B;
        start   = 1'b1;
        base    = acc_cnt;
        @(negedge clk);
        i_block = CT_C;
        key     = KEY_C;
        cur_exp = PT_C;
        k = 0;
        while (acc_cnt < base + 2 && k < 80) begin
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk("b2b_accepts", 128'(acc_cnt - base), 128'(2));
        wait_done(4);
        chk("b2b_spacing", 128'(last_done_cyc - prev_done_cyc), 128'(21));

        // Start with garbage while busy is ignored
        base = acc_cnt;
        issue(CT_B, KEY_B, PT_B);
        repeat (6) @(negedge clk);
        i_block = 128'hdeadbeef_0badf00d_cafebabe_01234567;
        key     = 128'hffffffff_00000000_a5a5a5a5_5a5a5a5a;
        cur_exp = 128'h0bad;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wait_done(5);
        repeat (25) @(negedge clk);
        chk("busy_start_ignored", 128'(acc_cnt - base), 128'(1));
        chk("no_extra_done", 128'(done_cnt), 128'(5));

        // Async reset in the middle of an operation
        issue(CT_B, KEY_B, PT_B);
        repeat (11) @(negedge clk);
        #2;
        rst    = 1'b1;
        last_o = '0;
        exp_q.delete();
        acc_q.delete();
        #1;
        chk("arst_ready", 128'(ready), 128'(1));
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_done", 128'(done), 128'(0));
        chk("arst_o_block", o_block, 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("no_done_after_rst", 128'(done_cnt), 128'(5));

        issue(CT_B, KEY_B, PT_B);
        wait_done(6);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
